// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: frame FSM state encoding,
// parity-mode codes, and the parity-bit helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // xor_all is the XOR reduction of the data word; odd parity inverts it so
  // that the total number of ones (data + parity) is odd.
  function automatic logic parity_bit(input logic xor_all, input int mode);
    return (mode == PARITY_ODD) ? ~xor_all : xor_all;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Bit-period timer for the UART transmitter. Counts 0..baudDivisor-1 and wraps.
// Ports:
//   clock   in  system clock, rising edge
//   reset   in  synchronous, active-high
//   restart in  forces the count to 0 on the next edge (aligns a new frame)
//   bitEnd  out high in the last clock cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_counter #(
  parameter int baudDivisor = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic bitEnd
);

  localparam int CntWidth = $clog2(baudDivisor);
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(baudDivisor - 1);

  logic [CntWidth-1:0] cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (restart || (cnt_reg == LastCount)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bitEnd = (cnt_reg == LastCount);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
// Pops words from a show-ahead FIFO and shifts each out as an asynchronous UART
// frame (start, data LSB first, optional parity, stop). Frames run back to back
// while the FIFO holds data; txd idles high otherwise.
// Ports:
//   clock      in  system clock, rising edge
//   reset      in  synchronous, active-high
//   txEnable   in  permission to start a new frame (looked at only at frame boundaries)
//   fifoEmpty  in  FIFO empty flag
//   fifoData   in  FIFO head word (valid while fifoEmpty = 0)
//   fifoPop    out one-cycle pop strobe, head removed at this clock edge
//   txd        out serial line, registered, idle high
//   busy       out high from the pop cycle through the last stop-bit cycle
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int bitWidth     = 8,
  parameter int baudDivisor  = 434,
  parameter int nrOfStopBits = 1,
  parameter int parityMode   = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                txEnable,
  input  logic                fifoEmpty,
  input  logic [bitWidth-1:0] fifoData,
  output logic                fifoPop,
  output logic                txd,
  output logic                busy
);

  localparam int BitCntWidth = $clog2(bitWidth + 1);
  localparam logic [BitCntWidth-1:0] LastDataBit = BitCntWidth'(bitWidth - 1);
  localparam logic LastStopBit = 1'(nrOfStopBits - 1);

  uart_state_t             state_reg, state_next;
  logic [bitWidth-1:0]     shift_reg, shift_next;
  logic [BitCntWidth-1:0]  bit_cnt_reg, bit_cnt_next;
  logic                    stop_cnt_reg, stop_cnt_next;
  logic                    parity_reg, parity_next;
  logic                    txd_reg, txd_next;
  logic                    bit_end;
  logic                    can_start;

  uart_baud_counter #(
    .baudDivisor(baudDivisor)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .restart(fifoPop),
    .bitEnd (bit_end)
  );

  // Reset gates the pop so nothing leaves the FIFO while the block is held.
  assign can_start = txEnable && !fifoEmpty && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      parity_reg   <= 1'b0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      parity_reg   <= parity_next;
      txd_reg      <= txd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    parity_next   = parity_reg;
    fifoPop       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (can_start) begin
          fifoPop       = 1'b1;
          shift_next    = fifoData;
          parity_next   = parity_bit(^fifoData, parityMode);
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          state_next    = START;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LastDataBit) begin
            bit_cnt_next = '0;
            state_next   = (parityMode != PARITY_NONE) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_reg == LastStopBit) begin
            // Last stop cycle: chain straight into the next frame if allowed.
            if (can_start) begin
              fifoPop       = 1'b1;
              shift_next    = fifoData;
              parity_next   = parity_bit(^fifoData, parityMode);
              bit_cnt_next  = '0;
              stop_cnt_next = 1'b0;
              state_next    = START;
            end else begin
              stop_cnt_next = 1'b0;
              state_next    = IDLE;
            end
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the upcoming state so txd can be registered
    // without adding a cycle of latency.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PARITY:  txd_next = parity_next;
      default: txd_next = 1'b1;
    endcase
  end

  assign txd  = txd_reg;
  assign busy = (state_reg != IDLE) || fifoPop;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
module tb_uart_tx_fifo_drain;

  localparam int DIV   = 4;
  localparam int FRAME = 40;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset     = 1'b1;
  logic       txEnable  = 1'b1;
  logic       fifoEmpty = 1'b1;
  logic [7:0] fifoData  = 8'h00;
  logic       fifoPop, txd, busy;

  logic       pe_empty = 1'b1, po_empty = 1'b1;
  logic [7:0] pe_data  = 8'h00, po_data = 8'h00;
  logic       pe_pop, po_pop, txd_e, txd_o, busy_e, busy_o;

  uart_tx_fifo_drain #(.bitWidth(8), .baudDivisor(DIV), .nrOfStopBits(1), .parityMode(0)) dut (
    .clock(clock), .reset(reset), .txEnable(txEnable), .fifoEmpty(fifoEmpty),
    .fifoData(fifoData), .fifoPop(fifoPop), .txd(txd), .busy(busy));

  uart_tx_fifo_drain #(.bitWidth(8), .baudDivisor(DIV), .nrOfStopBits(2), .parityMode(1)) dut_e (
    .clock(clock), .reset(reset), .txEnable(1'b1), .fifoEmpty(pe_empty),
    .fifoData(pe_data), .fifoPop(pe_pop), .txd(txd_e), .busy(busy_e));

  uart_tx_fifo_drain #(.bitWidth(8), .baudDivisor(DIV), .nrOfStopBits(1), .parityMode(2)) dut_o (
    .clock(clock), .reset(reset), .txEnable(1'b1), .fifoEmpty(po_empty),
    .fifoData(po_data), .fifoPop(po_pop), .txd(txd_o), .busy(busy_o));

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int pop_empty_err  = 0;
  int pop_consec_err = 0;
  logic prev_pop = 1'b0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [8:0] rx_q[$];
  int         pop_q[$];

  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic refresh_fifo();
    fifoEmpty = (fifo_q.size() == 0);
    fifoData  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_word(input logic [7:0] w, input bit expect_sent);
    fifo_q.push_back(w);
    if (expect_sent) exp_q.push_back(w);
    refresh_fifo();
  endtask

  // FIFO model + pop monitor: pops are observed at the edge, the head is
  // removed just after it.
  always @(posedge clock) begin
    logic pop_now;
    pop_now = (fifoPop === 1'b1);
    if (pop_now) begin
      pop_q.push_back(cyc);
      if (fifoEmpty) pop_empty_err++;
      if (prev_pop) pop_consec_err++;
    end
    prev_pop = pop_now;
    cyc++;
    #1;
    if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh_fifo();
  end

  // UART receiver for the main instance: mid-bit sampling, aborts on reset.
  logic       dec_active = 1'b0;
  int         dec_off    = 0;
  logic       dec_start_ok = 1'b0;
  logic [7:0] dec_byte   = 8'h00;
  always @(negedge clock) begin
    int idx;
    if (reset) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (txd === 1'b0) begin
        dec_active = 1'b1;
        dec_off    = 0;
      end
    end else begin
      dec_off++;
    end
    if (dec_active && (dec_off % DIV == DIV / 2)) begin
      idx = dec_off / DIV;
      if (idx == 0) dec_start_ok = (txd === 1'b0);
      else if (idx <= 8) dec_byte[idx-1] = txd;
      else begin
        rx_q.push_back({dec_start_ok && (txd === 1'b1), dec_byte});
        dec_active = 1'b0;
      end
    end
  end

  task automatic wait_rx(input int n, input int budget, input string tag);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      next_cycle();
      t++;
    end
    compared++;
    if (rx_q.size() < n) begin
      mismatched++;
      $display("FAIL %s rx_timeout: frames %0d, required %0d", tag, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) reset = 1'b0;
      next_cycle();
      compared += 3;
      if (txd !== 1'b1) begin mismatched++; $display("FAIL reset_txd cyc%0d: got %b, required 1", i, txd); end
      if (fifoPop !== 1'b0) begin mismatched++; $display("FAIL reset_pop cyc%0d: got %b, required 0", i, fifoPop); end
      if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy cyc%0d: got %b, required 0", i, busy); end
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] pat;
    logic [8:0] got, want;
    pat = {1'b1, 8'hA5, 1'b0};
    pop_q.delete();
    next_cycle();
    push_word(8'hA5, 1'b1);
    #1;
    compared += 2;
    if (fifoPop !== 1'b1) begin mismatched++; $display("FAIL single_pop: got %b, required 1", fifoPop); end
    if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy_pop: got %b, required 1", busy); end
    for (int k = 1; k <= FRAME; k++) begin
      next_cycle();
      compared += 2;
      if (txd !== pat[(k-1)/DIV]) begin
        mismatched++; $display("FAIL single_txd cyc%0d: got %b, required %b", k, txd, pat[(k-1)/DIV]);
      end
      if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy cyc%0d: got %b, required 1", k, busy); end
    end
    next_cycle();
    compared += 3;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_end: got %b, required 0", busy); end
    if (txd !== 1'b1) begin mismatched++; $display("FAIL single_txd_end: got %b, required 1", txd); end
    if (pop_q.size() != 1) begin mismatched++; $display("FAIL single_pop_count: got %0d, required 1", pop_q.size()); end
    wait_rx(1, 20, "single");
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      got = rx_q.pop_front(); want = {1'b1, exp_q.pop_front()};
      compared++;
      if (got !== want) begin mismatched++; $display("FAIL single_byte: got %h, required %h", got, want); end
    end
  endtask

  task automatic test_back_to_back();
    int t = 0;
    logic [8:0] got, want;
    pop_q.delete();
    next_cycle();
    for (int i = 1; i <= 32; i++) push_word(8'(i), 1'b1);
    while (pop_q.size() < 32 && t < 32 * FRAME + 50) begin
      next_cycle();
      t++;
    end
    repeat (60) next_cycle();
    compared++;
    if (pop_q.size() != 32) begin mismatched++; $display("FAIL b2b_pop_count: got %0d, required 32", pop_q.size()); end
    for (int i = 0; i + 1 < pop_q.size(); i++) begin
      compared++;
      if (pop_q[i+1] - pop_q[i] != FRAME) begin
        mismatched++; $display("FAIL b2b_gap %0d: got %0d, required %0d", i, pop_q[i+1] - pop_q[i], FRAME);
      end
    end
    wait_rx(32, 50, "b2b");
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      got = rx_q.pop_front(); want = {1'b1, exp_q.pop_front()};
      compared++;
      if (got !== want) begin mismatched++; $display("FAIL b2b_byte: got %h, required %h", got, want); end
    end
    compared += 3;
    if (fifoEmpty !== 1'b1) begin mismatched++; $display("FAIL b2b_fifo_empty: got %b, required 1", fifoEmpty); end
    if (pop_empty_err != 0) begin mismatched++; $display("FAIL pop_when_empty: got %0d, required 0", pop_empty_err); end
    if (pop_consec_err != 0) begin mismatched++; $display("FAIL consecutive_pop: got %0d, required 0", pop_consec_err); end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    d = 8'h07;
    next_cycle();
    pe_data = d; po_data = d; pe_empty = 1'b0; po_empty = 1'b0;
    #1;
    compared += 2;
    if (pe_pop !== 1'b1) begin mismatched++; $display("FAIL even_pop: got %b, required 1", pe_pop); end
    if (po_pop !== 1'b1) begin mismatched++; $display("FAIL odd_pop: got %b, required 1", po_pop); end
    for (int k = 1; k <= 50; k++) begin
      next_cycle();
      if (k == 1) begin pe_empty = 1'b1; po_empty = 1'b1; end
      for (int w = 0; w < 2; w++) begin
        int len, bi;
        logic et, eb, gt, gb;
        len = (w == 0) ? 48 : 44;
        bi  = (k - 1) / DIV;
        if (k > len) begin
          et = 1'b1; eb = 1'b0;
        end else begin
          eb = 1'b1;
          if (bi == 0) et = 1'b0;
          else if (bi <= 8) et = d[bi-1];
          else if (bi == 9) et = (w == 0) ? ^d : ~^d;
          else et = 1'b1;
        end
        gt = (w == 0) ? txd_e : txd_o;
        gb = (w == 0) ? busy_e : busy_o;
        compared += 2;
        if (gt !== et) begin mismatched++; $display("FAIL parity%0d_txd cyc%0d: got %b, required %b", w, k, gt, et); end
        if (gb !== eb) begin mismatched++; $display("FAIL parity%0d_busy cyc%0d: got %b, required %b", w, k, gb, eb); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] got, want;
    pop_q.delete();
    rx_q.delete();
    next_cycle();
    push_word(8'h3C, 1'b0);
    #1;
    compared++;
    if (fifoPop !== 1'b1) begin mismatched++; $display("FAIL rst_first_pop: got %b, required 1", fifoPop); end
    repeat (18) next_cycle();
    compared++;
    if (txd !== 1'b1) begin mismatched++; $display("FAIL rst_data_bit3: got %b, required 1", txd); end
    reset = 1'b1;
    push_word(8'h81, 1'b1);
    #1;
    compared++;
    if (fifoPop !== 1'b0) begin mismatched++; $display("FAIL rst_pop_during: got %b, required 0", fifoPop); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      compared += 3;
      if (fifoPop !== 1'b0) begin mismatched++; $display("FAIL rst_pop cyc%0d: got %b, required 0", i, fifoPop); end
      if (txd !== 1'b1) begin mismatched++; $display("FAIL rst_txd cyc%0d: got %b, required 1", i, txd); end
      if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy cyc%0d: got %b, required 0", i, busy); end
    end
    reset = 1'b0;
    #1;
    compared++;
    if (fifoPop !== 1'b1) begin mismatched++; $display("FAIL rst_release_pop: got %b, required 1", fifoPop); end
    wait_rx(1, 60, "rst");
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      got = rx_q.pop_front(); want = {1'b1, exp_q.pop_front()};
      compared++;
      if (got !== want) begin mismatched++; $display("FAIL rst_byte: got %h, required %h", got, want); end
    end
    compared++;
    if (pop_q.size() != 2) begin mismatched++; $display("FAIL rst_pop_count: got %0d, required 2", pop_q.size()); end
  endtask

  task automatic test_tx_enable();
    logic [8:0] got, want;
    pop_q.delete();
    txEnable = 1'b0;
    next_cycle();
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    repeat (100) next_cycle();
    compared += 2;
    if (pop_q.size() != 0) begin mismatched++; $display("FAIL en_hold_pops: got %0d, required 0", pop_q.size()); end
    if (txd !== 1'b1) begin mismatched++; $display("FAIL en_hold_txd: got %b, required 1", txd); end
    txEnable = 1'b1;
    #1;
    compared++;
    if (fifoPop !== 1'b1) begin mismatched++; $display("FAIL en_raise_pop: got %b, required 1", fifoPop); end
    repeat (10) next_cycle();
    txEnable = 1'b0;
    repeat (80) next_cycle();
    compared += 2;
    if (pop_q.size() != 1) begin mismatched++; $display("FAIL en_drop_pops: got %0d, required 1", pop_q.size()); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL en_drop_busy: got %b, required 0", busy); end
    wait_rx(1, 20, "en_drop");
    while (rx_q.size() != 0 && exp_q.size() != 0) begin
      got = rx_q.pop_front(); want = {1'b1, exp_q.pop_front()};
      compared++;
      if (got !== want) begin mismatched++; $display("FAIL en_byte: got %h, required %h", got, want); end
    end
    txEnable = 1'b1;
    wait_rx(2, 2 * FRAME + 30, "en_resume");
    while (rx_q.size() != 0 && exp_q.size() != 0) begin
      got = rx_q.pop_front(); want = {1'b1, exp_q.pop_front()};
      compared++;
      if (got !== want) begin mismatched++; $display("FAIL en_resume_byte: got %h, required %h", got, want); end
    end
    compared++;
    if (pop_q.size() != 3) begin mismatched++; $display("FAIL en_total_pops: got %0d, required 3", pop_q.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_reset_mid_frame();
    test_tx_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
